// File: rtl/traffic_pkg.sv
// Shared state encoding and lamp codes for the traffic phase controller,
// its lamp drivers and its testbench.
package traffic_pkg;

  typedef enum logic [1:0] {
    ALL_RED = 2'b00,
    GREEN   = 2'b01,
    YELLOW  = 2'b10
  } phase_state_t;

  localparam logic [1:0] LAMP_RED    = 2'b00;
  localparam logic [1:0] LAMP_GREEN  = 2'b01;
  localparam logic [1:0] LAMP_YELLOW = 2'b10;

  function automatic logic [1:0] lamp_code(input phase_state_t s);
    case (s)
      GREEN:   return LAMP_GREEN;
      YELLOW:  return LAMP_YELLOW;
      default: return LAMP_RED;
    endcase
  endfunction

endpackage

// File: rtl/rr_phase_select.sv
// Combinational round-robin search: the first set bit of 'pending' found
// walking upward from 'start' (wrapping) wins; 'valid' says one was found.
module rr_phase_select #(
  parameter int NUM_PHASES = 4
) (
  input  logic [NUM_PHASES-1:0]         pending,
  input  logic [$clog2(NUM_PHASES)-1:0] start,
  output logic [$clog2(NUM_PHASES)-1:0] winner,
  output logic                          valid
);

  localparam int AW = $clog2(NUM_PHASES);

  int idx;

  always_comb begin
    winner = start;
    valid  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      idx = int'(start) + i;
      if (idx >= NUM_PHASES) idx = idx - NUM_PHASES;
      if (!valid && pending[idx]) begin
        winner = AW'(idx);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_phase_controller.sv
// N-approach signal controller: GREEN -> YELLOW -> ALL_RED per phase, round-robin
// service of latched requests. Optional emergency preemption under `define PREEMPT_EN.
module traffic_phase_controller
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES   = 4,
  parameter int TICK_DIV     = 1000,
  parameter int MIN_GREEN    = 5,
  parameter int MAX_GREEN    = 20,
  parameter int YELLOW_TIME  = 3,
  parameter int ALL_RED_TIME = 1,
  parameter int TIMER_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PHASES-1:0]         req,
`ifdef PREEMPT_EN
  input  logic                          preempt,
  input  logic [$clog2(NUM_PHASES)-1:0] preempt_phase,
  output logic                          preempt_active,
`endif
  output logic [2*NUM_PHASES-1:0]       lights,
  output logic [$clog2(NUM_PHASES)-1:0] active_phase,
  output logic [1:0]                    state,
  output logic [TIMER_W-1:0]            second,
  output logic [NUM_PHASES-1:0]         pending
);

  localparam int AW = $clog2(NUM_PHASES);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0]      TICK_LAST  = PW'(TICK_DIV - 1);
  localparam logic [TIMER_W-1:0] SEC_MAX    = '1;
  localparam logic [TIMER_W-1:0] MIN_LAST   = TIMER_W'(MIN_GREEN - 1);
  localparam logic [TIMER_W-1:0] MAX_LAST   = TIMER_W'(MAX_GREEN - 1);
  localparam logic [TIMER_W-1:0] YEL_LAST   = TIMER_W'(YELLOW_TIME - 1);
  localparam logic [TIMER_W-1:0] AR_LAST    = TIMER_W'(ALL_RED_TIME - 1);
  localparam logic [AW-1:0]      LAST_PHASE = AW'(NUM_PHASES - 1);

  phase_state_t            state_q, state_d;
  logic [AW-1:0]           active_q, active_d;
  logic [PW-1:0]           presc_q;
  logic [TIMER_W-1:0]      second_q;
  logic [NUM_PHASES-1:0]   pending_q, pending_d;
  logic [NUM_PHASES-1:0]   clear_mask, active_mask;
  logic [2*NUM_PHASES-1:0] lights_q, lights_d;

  logic          tick;
  logic          other;
  logic          state_change;
  logic          green_done;
  logic          sel_valid;
  logic [AW-1:0] start, sel_phase, grant_phase;
  logic          preempt_force, preempt_hold;

  assign tick         = (presc_q == TICK_LAST);
  assign start        = (active_q == LAST_PHASE) ? '0 : active_q + AW'(1);
  assign state_change = (state_d != state_q);

  always_comb begin
    active_mask           = '0;
    active_mask[active_q] = 1'b1;
  end

  assign other = |(pending_q & ~active_mask);

  // MAX_GREEN only matters if configured below MIN_GREEN; otherwise MIN governs.
  assign green_done = tick && other && ((second_q >= MIN_LAST) || (second_q >= MAX_LAST));

  rr_phase_select #(
    .NUM_PHASES(NUM_PHASES)
  ) u_select (
    .pending(pending_q),
    .start  (start),
    .winner (sel_phase),
    .valid  (sel_valid)
  );

`ifdef PREEMPT_EN
  logic          pre_q;
  logic [AW-1:0] pre_phase_q;
  logic [AW-1:0] pre_phase_in;
  logic [AW-1:0] pre_phase_eff;
  logic          pre_eff;

  // Raw preempt acts on the very edge it is first seen, before the latch catches up.
  assign pre_phase_in  = (preempt_phase > LAST_PHASE) ? LAST_PHASE : preempt_phase;
  assign pre_eff       = preempt | pre_q;
  assign pre_phase_eff = preempt ? pre_phase_in : pre_phase_q;
  assign grant_phase   = pre_eff ? pre_phase_eff : (sel_valid ? sel_phase : active_q);
  assign preempt_force = pre_eff && (active_q != pre_phase_eff);
  assign preempt_hold  = preempt && (active_q == pre_phase_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q       <= 1'b0;
      pre_phase_q <= '0;
    end else if (preempt) begin
      pre_q       <= 1'b1;
      pre_phase_q <= pre_phase_in;
    end else if (state_q == GREEN && active_q == pre_phase_q) begin
      pre_q       <= 1'b0;
    end
  end

  assign preempt_active = pre_q;
`else
  assign grant_phase   = sel_valid ? sel_phase : active_q;
  assign preempt_force = 1'b0;
  assign preempt_hold  = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    clear_mask = '0;
    case (state_q)
      ALL_RED: begin
        if (tick && second_q == AR_LAST) begin
          state_d                 = GREEN;
          active_d                = grant_phase;
          clear_mask[grant_phase] = 1'b1;
        end
      end
      GREEN: begin
        if (preempt_force) begin
          state_d = YELLOW;
        end else if (!preempt_hold && green_done) begin
          state_d = YELLOW;
        end
      end
      YELLOW: begin
        if (tick && second_q == YEL_LAST) state_d = ALL_RED;
      end
      default: state_d = ALL_RED;
    endcase
  end

  // A request arriving on its own grant cycle is dropped; it re-latches next cycle.
  assign pending_d = (pending_q | req) & ~clear_mask;

  always_comb begin
    lights_d = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      lights_d[2*i +: 2] = (AW'(i) == active_d) ? lamp_code(state_d) : LAMP_RED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ALL_RED;
      active_q  <= '0;
      presc_q   <= '0;
      second_q  <= '0;
      pending_q <= '0;
      lights_q  <= '0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      lights_q  <= lights_d;
      if (state_change) begin
        presc_q  <= '0;
        second_q <= '0;
      end else begin
        presc_q <= tick ? '0 : presc_q + PW'(1);
        if (tick && second_q != SEC_MAX) second_q <= second_q + TIMER_W'(1);
      end
    end
  end

  assign lights       = lights_q;
  assign active_phase = active_q;
  assign state        = state_q;
  assign second       = second_q;
  assign pending      = pending_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Self-checking bench for traffic_phase_controller: directed scenarios plus
// randomized requests against a cycle-count reference model. Covers PREEMPT_EN when defined.
module tb_traffic_phase_controller;
  import traffic_pkg::*;

  localparam int N    = 4;
  localparam int TICK = 4;
  localparam int MINS = 2;
  localparam int MAXS = 5;
  localparam int YEL  = 2;
  localparam int AR   = 1;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       preempt;
  logic [1:0] preempt_phase;
  logic       preempt_active;
  logic [7:0] lights;
  logic [1:0] active_phase;
  logic [1:0] state;
  logic [7:0] second;
  logic [3:0] pending;

  int n_checks;
  int n_fail;

  traffic_phase_controller #(
    .NUM_PHASES(N), .TICK_DIV(TICK), .MIN_GREEN(MINS), .MAX_GREEN(MAXS),
    .YELLOW_TIME(YEL), .ALL_RED_TIME(AR), .TIMER_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
`ifdef PREEMPT_EN
    .preempt(preempt),
    .preempt_phase(preempt_phase),
    .preempt_active(preempt_active),
`endif
    .lights(lights),
    .active_phase(active_phase),
    .state(state),
    .second(second),
    .pending(pending)
  );

`ifndef PREEMPT_EN
  assign preempt_active = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: time is cycles since the state was entered; seconds derive from it.
  phase_state_t m_state;
  int           m_act;
  int           m_cyc;
  logic [3:0]   m_pend;
  logic         m_pre;
  int           m_pre_ph;

  function automatic logic [7:0] exp_lights();
    logic [7:0] v;
    v = '0;
    if (m_state == GREEN)  v[2*m_act +: 2] = LAMP_GREEN;
    if (m_state == YELLOW) v[2*m_act +: 2] = LAMP_YELLOW;
    return v;
  endfunction

  function automatic int exp_second();
    int s;
    s = m_cyc / TICK;
    if (s > 255) s = 255;
    return s;
  endfunction

  task automatic model_update(input logic [3:0] r, input logic rs, input logic p, input int pp);
    phase_state_t nxt;
    int  nact, clr, sec, pre_ph;
    bit  tk, others, pre_eff;
    if (rs) begin
      m_state = ALL_RED; m_act = 0; m_cyc = 0; m_pend = '0; m_pre = 1'b0; m_pre_ph = 0;
      return;
    end
    tk      = (m_cyc % TICK) == TICK - 1;
    sec     = m_cyc / TICK;
    pre_eff = p || m_pre;
    pre_ph  = p ? pp : m_pre_ph;
    nxt     = m_state;
    nact    = m_act;
    clr     = -1;
    others  = 1'b0;
    for (int i = 0; i < N; i++) if (i != m_act && m_pend[i]) others = 1'b1;
    case (m_state)
      ALL_RED: if (tk && sec == AR - 1) begin
        nxt = GREEN;
        if (pre_eff) nact = pre_ph;
        else begin
          nact = m_act;
          for (int k = N; k >= 1; k--) if (m_pend[(m_act + k) % N]) nact = (m_act + k) % N;
        end
        clr = nact;
      end
      GREEN: begin
        if (pre_eff && m_act != pre_ph) nxt = YELLOW;
        else if (p && m_act == pp) nxt = GREEN;
        else if (tk && others && sec >= MINS - 1) nxt = YELLOW;
      end
      YELLOW: if (tk && sec == YEL - 1) nxt = ALL_RED;
      default: nxt = ALL_RED;
    endcase
    if (p) begin m_pre = 1'b1; m_pre_ph = pp; end
    else if (m_state == GREEN && m_act == m_pre_ph) m_pre = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i == clr) m_pend[i] = 1'b0;
      else if (r[i]) m_pend[i] = 1'b1;
    end
    m_cyc   = (nxt != m_state) ? 0 : m_cyc + 1;
    m_state = nxt;
    m_act   = nact;
  endtask

  // One clock: inputs seen by the DUT at this edge also advance the model.
  task automatic step();
    logic [3:0] r;
    logic rs, p;
    int pp;
    r = req; rs = rst; p = preempt; pp = int'(preempt_phase);
    @(posedge clk);
    #1;
    model_update(r, rs, p, pp);
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0;
    step(); step();
    n_checks++; if (state !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_state: got %b expected 00", state); end
    n_checks++; if (lights !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_lights: got %b expected 00000000", lights); end
    n_checks++; if (active_phase !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_active: got %0d expected 0", active_phase); end
    n_checks++; if (second !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_second: got %0d expected 0", second); end
    n_checks++; if (pending !== 4'b0) begin n_fail++; $display("[TB] FAIL reset_pending: got %b expected 0000", pending); end
    rst = 1'b0;
    repeat (3) step();
    n_checks++; if (state !== 2'b00) begin n_fail++; $display("[TB] FAIL allred_3clk: got %b expected 00", state); end
    step();
    n_checks++; if (state !== 2'b01) begin n_fail++; $display("[TB] FAIL first_green_state: got %b expected 01", state); end
    n_checks++; if (lights !== 8'b00_00_00_01) begin n_fail++; $display("[TB] FAIL first_green_lights: got %b expected 00000001", lights); end
    n_checks++; if (active_phase !== 2'd0) begin n_fail++; $display("[TB] FAIL first_green_active: got %0d expected 0", active_phase); end
  endtask

  task automatic test_rest_in_green();
    repeat (40) step();
    n_checks++; if (second !== 8'd10) begin n_fail++; $display("[TB] FAIL second_count: got %0d expected 10", second); end
    repeat (1060) step();
    n_checks++; if (second !== 8'd255) begin n_fail++; $display("[TB] FAIL second_saturate: got %0d expected 255", second); end
    n_checks++; if (state !== 2'b01 || lights !== 8'b00_00_00_01) begin
      n_fail++; $display("[TB] FAIL rest_green: got state %b lights %b expected 01 00000001", state, lights);
    end
  endtask

  task automatic test_single_request();
    rst = 1'b1; step(); rst = 1'b0;
    repeat (4) step();
    req = 4'b0100; step(); req = '0;
    n_checks++; if (pending !== 4'b0100) begin n_fail++; $display("[TB] FAIL req_latch: got %b expected 0100", pending); end
    repeat (6) step();
    n_checks++; if (state !== 2'b01) begin n_fail++; $display("[TB] FAIL green_7clk: got %b expected 01", state); end
    step();
    n_checks++; if (state !== 2'b10 || lights !== 8'b00_00_00_10) begin
      n_fail++; $display("[TB] FAIL yellow_8clk: got state %b lights %b expected 10 00000010", state, lights);
    end
    n_checks++; if (second !== 8'd0) begin n_fail++; $display("[TB] FAIL yellow_second: got %0d expected 0", second); end
    repeat (7) step();
    n_checks++; if (state !== 2'b10) begin n_fail++; $display("[TB] FAIL yellow_hold: got %b expected 10", state); end
    step();
    n_checks++; if (state !== 2'b00 || lights !== 8'h00) begin
      n_fail++; $display("[TB] FAIL allred_after_yellow: got state %b lights %b expected 00 00000000", state, lights);
    end
    repeat (3) step();
    n_checks++; if (state !== 2'b00) begin n_fail++; $display("[TB] FAIL allred_hold: got %b expected 00", state); end
    step();
    n_checks++; if (state !== 2'b01 || active_phase !== 2'd2 || lights !== 8'b00_01_00_00) begin
      n_fail++; $display("[TB] FAIL grant_phase2: got state %b active %0d lights %b expected 01 2 00010000", state, active_phase, lights);
    end
    n_checks++; if (pending !== 4'b0000) begin n_fail++; $display("[TB] FAIL pending_cleared: got %b expected 0000", pending); end
  endtask

  task automatic test_wrap_order();
    int cnt;
    int exp_seq[3] = '{1, 2, 3};
    req = 4'b1000; step(); req = '0;
    cnt = 0; while (state === 2'b01 && cnt < 100) begin step(); cnt++; end
    cnt = 0; while (state !== 2'b01 && cnt < 100) begin step(); cnt++; end
    n_checks++; if (state !== 2'b01 || active_phase !== 2'd3) begin
      n_fail++; $display("[TB] FAIL reach_phase3: got state %b active %0d expected 01 3", state, active_phase);
    end
    step();
    req = 4'b1110; step(); req = '0;
    for (int k = 0; k < 3; k++) begin
      cnt = 0; while (state === 2'b01 && cnt < 100) begin step(); cnt++; end
      cnt = 0; while (state !== 2'b01 && cnt < 100) begin step(); cnt++; end
      n_checks++; if (state !== 2'b01 || active_phase !== 2'(exp_seq[k])) begin
        n_fail++; $display("[TB] FAIL wrap_grant_%0d: got state %b active %0d expected 01 %0d", k, state, active_phase, exp_seq[k]);
      end
    end
    repeat (40) step();
    n_checks++; if (state !== 2'b01 || active_phase !== 2'd3 || pending !== 4'b0) begin
      n_fail++; $display("[TB] FAIL wrap_rest: got state %b active %0d pending %b expected 01 3 0000", state, active_phase, pending);
    end
  endtask

  task automatic test_held_request();
    int cnt;
    req = 4'b0010;
    cnt = 0; while (state === 2'b01 && cnt < 100) begin step(); cnt++; end
    cnt = 0; while (state !== 2'b01 && cnt < 100) begin step(); cnt++; end
    n_checks++; if (active_phase !== 2'd1 || state !== 2'b01) begin
      n_fail++; $display("[TB] FAIL held_grant1: got state %b active %0d expected 01 1", state, active_phase);
    end
    n_checks++; if (pending[1] !== 1'b0) begin n_fail++; $display("[TB] FAIL clear_wins: got %b expected 0", pending[1]); end
    req = 4'b1010; step(); req = 4'b0010;
    n_checks++; if (pending !== 4'b1010) begin n_fail++; $display("[TB] FAIL relatch: got %b expected 1010", pending); end
    cnt = 1; while (state === 2'b01 && cnt < 100) begin step(); cnt++; end
    n_checks++; if (cnt !== 8) begin n_fail++; $display("[TB] FAIL min_green_len: got %0d clk expected 8", cnt); end
    cnt = 0; while (state !== 2'b01 && cnt < 100) begin step(); cnt++; end
    n_checks++; if (active_phase !== 2'd3) begin n_fail++; $display("[TB] FAIL held_then3: got %0d expected 3", active_phase); end
    cnt = 0; while (state === 2'b01 && cnt < 100) begin step(); cnt++; end
    cnt = 0; while (state !== 2'b01 && cnt < 100) begin step(); cnt++; end
    n_checks++; if (active_phase !== 2'd1 || state !== 2'b01) begin
      n_fail++; $display("[TB] FAIL held_back1: got state %b active %0d expected 01 1", state, active_phase);
    end
    req = '0;
  endtask

  task automatic test_reset_in_yellow();
    int cnt;
    req = 4'b0100; step(); req = '0;
    cnt = 0; while (state !== 2'b10 && cnt < 100) begin step(); cnt++; end
    n_checks++; if (state !== 2'b10) begin n_fail++; $display("[TB] FAIL reach_yellow: got %b expected 10", state); end
    step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    n_checks++; if (state !== 2'b00 || lights !== 8'h00 || second !== 8'd0 || active_phase !== 2'd0) begin
      n_fail++; $display("[TB] FAIL rst_in_yellow: got state %b lights %b second %0d active %0d expected 00 0 0 0", state, lights, second, active_phase);
    end
  endtask

  task automatic test_random();
    rst = 1'b1; step(); rst = 1'b0;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) req[i] = ($urandom_range(0, 19) == 0);
      step();
      n_checks++; if (state !== m_state) begin n_fail++; $display("[TB] FAIL rand_state@%0d: got %b expected %b", c, state, m_state); end
      n_checks++; if (active_phase !== 2'(m_act)) begin n_fail++; $display("[TB] FAIL rand_active@%0d: got %0d expected %0d", c, active_phase, m_act); end
      n_checks++; if (lights !== exp_lights()) begin n_fail++; $display("[TB] FAIL rand_lights@%0d: got %b expected %b", c, lights, exp_lights()); end
      n_checks++; if (second !== 8'(exp_second())) begin n_fail++; $display("[TB] FAIL rand_second@%0d: got %0d expected %0d", c, second, exp_second()); end
      n_checks++; if (pending !== m_pend) begin n_fail++; $display("[TB] FAIL rand_pending@%0d: got %b expected %b", c, pending, m_pend); end
    end
    req = '0;
  endtask

`ifdef PREEMPT_EN
  task automatic test_preempt();
    int cnt;
    rst = 1'b1; step(); rst = 1'b0;
    repeat (4) step();
    preempt = 1'b1; preempt_phase = 2'd2;
    step();
    n_checks++; if (state !== 2'b10 || preempt_active !== 1'b1) begin
      n_fail++; $display("[TB] FAIL preempt_yellow: got state %b pa %b expected 10 1", state, preempt_active);
    end
    repeat (8) step();
    n_checks++; if (state !== 2'b00 || preempt_active !== 1'b1) begin
      n_fail++; $display("[TB] FAIL preempt_allred: got state %b pa %b expected 00 1", state, preempt_active);
    end
    repeat (4) step();
    n_checks++; if (state !== 2'b01 || active_phase !== 2'd2 || preempt_active !== 1'b1) begin
      n_fail++; $display("[TB] FAIL preempt_green: got state %b active %0d pa %b expected 01 2 1", state, active_phase, preempt_active);
    end
    req = 4'b0001; step(); req = '0;
    repeat (20) step();
    n_checks++; if (state !== 2'b01 || active_phase !== 2'd2) begin
      n_fail++; $display("[TB] FAIL preempt_hold: got state %b active %0d expected 01 2", state, active_phase);
    end
    preempt = 1'b0; step();
    n_checks++; if (preempt_active !== 1'b0) begin n_fail++; $display("[TB] FAIL preempt_release: got %b expected 0", preempt_active); end
    cnt = 0; while (state !== 2'b10 && cnt < 10) begin step(); cnt++; end
    n_checks++; if (state !== 2'b10 || active_phase !== 2'd2) begin
      n_fail++; $display("[TB] FAIL preempt_resume: got state %b active %0d expected 10 2", state, active_phase);
    end
  endtask
`endif

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; req = '0; preempt = 1'b0; preempt_phase = '0;
    m_state = ALL_RED; m_act = 0; m_cyc = 0; m_pend = '0; m_pre = 1'b0; m_pre_ph = 0;
    test_reset();
    test_rest_in_green();
    test_single_request();
    test_wrap_order();
    test_held_request();
    test_reset_in_yellow();
    test_random();
`ifdef PREEMPT_EN
    test_preempt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
